ram_sweeper: RTL

Bus-initiator engine that drives the data RAM's store/address/data port and reads its combinational result port. It has two modes, selected at start. Dump mode reads a block of consecutive words and streams them out over a valid/ready interface; a UART or debug host consumes the stream. Clear mode writes a fill value into a block of consecutive words, replacing reset-time clearing of the RAM.

---
 rtl/ram_sweeper_pkg.sv | 20 ++
 rtl/ram_sweeper_if.sv | 46 ++++
 rtl/ram_sweeper.sv | 110 +++++++++++
 3 files changed

// File: rtl/ram_sweeper_pkg.sv
// ram_sweeper_pkg: state encoding and RAM geometry shared by the sweeper and the data RAM.
// Rev 1.0
`default_nettype none

package ram_sweeper_pkg;

  localparam int RAM_ADDR_WIDTH = 10;
  localparam int RAM_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SEND  = 3'd2,
    ST_CLEAR = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/ram_sweeper_if.sv
// ram_sweeper_if: control, RAM port and output stream of the sweeper in one bundle.
// Rev 1.0
`default_nettype none

interface ram_sweeper_if
  import ram_sweeper_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = RAM_DATA_WIDTH
);

  logic                  start;
  logic                  clear_mode;
  logic [ADDR_WIDTH-3:0] first_word;
  logic [ADDR_WIDTH-2:0] word_count;
  logic [DATA_WIDTH-1:0] fill_value;
  logic                  busy;
  logic                  done;

  logic                  ram_store;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic [DATA_WIDTH-1:0] ram_data;
  logic [DATA_WIDTH-1:0] ram_result;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    input  start, clear_mode, first_word, word_count, fill_value,
    input  ram_result, out_ready,
    output busy, done, ram_store, ram_address, ram_data,
    output out_valid, out_data, out_last
  );

  modport slave (
    output start, clear_mode, first_word, word_count, fill_value,
    output ram_result, out_ready,
    input  busy, done, ram_store, ram_address, ram_data,
    input  out_valid, out_data, out_last
  );

endinterface

`default_nettype wire

// File: rtl/ram_sweeper.sv
// ram_sweeper: walks a block of RAM words, either streaming them out (dump) or overwriting them (clear).
// Rev 1.0
`default_nettype none

module ram_sweeper
  import ram_sweeper_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = RAM_DATA_WIDTH
) (
  input  logic          clock,
  input  logic          reset,
  ram_sweeper_if.master bus
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int CNT_W = ADDR_WIDTH - 1;

  state_e                state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [CNT_W-1:0]      remaining_q;
  logic [DATA_WIDTH-1:0] fill_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_valid_q;
  logic                  out_last_q;

  logic [IDX_W-1:0]      idx_d;
  logic [CNT_W-1:0]      remaining_d;
  logic                  out_last_d;

  // idx wraps naturally at 2^IDX_W words
  assign idx_d       = idx_q + 1'b1;
  assign remaining_d = remaining_q - 1'b1;
  assign out_last_d  = (remaining_q == CNT_W'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      remaining_q <= '0;
      fill_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            idx_q       <= bus.first_word;
            remaining_q <= bus.word_count;
            fill_q      <= bus.fill_value;
            if (bus.word_count == '0)
              state_q <= ST_DONE;
            else if (bus.clear_mode)
              state_q <= ST_CLEAR;
            else
              state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          out_data_q  <= bus.ram_result;
          out_valid_q <= 1'b1;
          out_last_q  <= out_last_d;
          idx_q       <= idx_d;
          remaining_q <= remaining_d;
          state_q     <= ST_SEND;
        end
        ST_SEND: begin
          // the address already points at the next word, so it is captured on the handshake edge
          if (out_valid_q && bus.out_ready) begin
            if (remaining_q != '0) begin
              out_data_q  <= bus.ram_result;
              out_last_q  <= out_last_d;
              idx_q       <= idx_d;
              remaining_q <= remaining_d;
            end else begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              state_q     <= ST_DONE;
            end
          end
        end
        ST_CLEAR: begin
          idx_q       <= idx_d;
          remaining_q <= remaining_d;
          if (remaining_q == CNT_W'(1))
            state_q <= ST_DONE;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ram_store   = (state_q == ST_CLEAR);
  assign bus.ram_address = {idx_q, 2'b00};
  assign bus.ram_data    = fill_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_last    = out_last_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = (state_q == ST_DONE);

endmodule

`default_nettype wire
